// File: rtl/ifu_pkg.sv
// Shared fetch-stage constants: canonical NOP encoding and default reset PC.
// Imported by the fetch unit and reusable by decode/execute.
package ifu_pkg;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifu_if.sv
// Instruction bus: req/gnt address phase, in-order rvalid data phase.
interface ifu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer with synchronous flush; head entry is
// visible on rdata whenever the FIFO is non-empty.
module ifu_fifo #(
    parameter int DATAW = 65,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DATAW-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [DATAW-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, issues credit-limited in-order
// bus requests, buffers {pc, err, instr} and presents one entry per cycle.
module ifu
    import ifu_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] RESET_PC   = AW'(DEFAULT_RESET_PC),
    parameter int            FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_jump_valid,
    input  logic [AW-1:0] i_jump_addr,
    input  logic          i_holding,
    ifu_if.master         ibus,
    output logic [AW-1:0] o_pc,
    output logic [DW-1:0] o_instr,
    output logic          o_instr_valid,
    output logic          o_fetch_err
);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FDW = AW + 1 + DW;
    localparam logic [DW-1:0] NOP = DW'(INSTR_NOP);

    logic [AW-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, jump_tgt;
    logic [CW-1:0]  outst_q, outst_d, discard_q, discard_d, fifo_count;
    logic [CW:0]    inflight;
    logic           req, fire, rsp, push, pop;
    logic           fifo_full, fifo_empty;
    logic [FDW-1:0] fifo_wdata, fifo_rdata;
    logic           unused_addr_lsb;

    assign jump_tgt        = {i_jump_addr[AW-1:2], 2'b00};
    assign unused_addr_lsb = ^i_jump_addr[1:0];

    // Credits cover both buffered entries and responses still on the bus, so a
    // push always finds room. rst_n gating keeps req low while held in reset.
    assign inflight = {1'b0, outst_q} + {1'b0, fifo_count};
    assign req      = rst_n && !i_jump_valid && (inflight < (CW+1)'(FIFO_DEPTH));
    assign fire     = req && ibus.gnt;
    assign rsp      = ibus.rvalid && (outst_q != '0);
    assign push     = rsp && (discard_q == '0) && !i_jump_valid && !fifo_full;
    assign pop      = !fifo_empty && !i_holding && !i_jump_valid;

    assign ibus.req  = req;
    assign ibus.addr = fetch_pc_q;

    assign fifo_wdata = {resp_pc_q, ibus.err, ibus.err ? NOP : ibus.rdata};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(fire) - CW'(rsp);
        discard_d  = discard_q;
        if (i_jump_valid) begin
            fetch_pc_d = jump_tgt;
            resp_pc_d  = jump_tgt;
            discard_d  = outst_q - CW'(rsp);
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + AW'(4);
            if (push) resp_pc_d  = resp_pc_q + AW'(4);
            if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    ifu_fifo #(.DATAW(FDW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .flush (i_jump_valid),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign o_instr_valid = !fifo_empty;
    assign o_pc          = o_instr_valid ? fifo_rdata[FDW-1 -: AW] : '0;
    assign o_fetch_err   = o_instr_valid && fifo_rdata[DW];
    assign o_instr       = o_instr_valid ? fifo_rdata[DW-1:0] : NOP;
endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: behavioural instruction bus plus a stream monitor
// recording every entry decode consumes.
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jaddr = '0;
    logic        hold = 1'b0;
    logic [31:0] pc, instr;
    logic        vld, ferr;

    int pass_cnt = 0;
    int total_cnt = 0;

    ifu_if #(.AW(32), .DW(32)) bus ();

    ifu dut (
        .clk(clk), .rst_n(rst_n), .i_jump_valid(jump), .i_jump_addr(jaddr),
        .i_holding(hold), .ibus(bus), .o_pc(pc), .o_instr(instr),
        .o_instr_valid(vld), .o_fetch_err(ferr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    typedef struct { logic [31:0] addr; int rdy; } tx_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;
    tx_t  bq[$];
    ent_t obs[$];
    tx_t  t;
    int   cyc = 0;
    bit   rand_gnt = 0, rand_dly = 0, err_en = 0;
    int   fix_dly = 0;
    logic [31:0] err_pc = 32'h8;

    // Bus model: grants sampled at the edge, responses driven #1 after it.
    initial begin
        bus.gnt = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
    end
    always begin
        @(posedge clk);
        cyc++;
        if (!rst_n) bq.delete();
        else if (bus.req && bus.gnt)
            bq.push_back('{bus.addr, cyc + (rand_dly ? int'($urandom_range(0, 5)) : fix_dly)});
        #1;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        if (rst_n && bq.size() > 0 && bq[0].rdy <= cyc) begin
            t = bq.pop_front();
            bus.rvalid = 1'b1;
            bus.rdata  = mem(t.addr);
            bus.err    = err_en && (t.addr == err_pc);
        end
        bus.gnt = rand_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk)
        if (rst_n && vld && !hold && !jump) obs.push_back('{pc, instr, ferr});

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; hold = 1'b0; jump = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt += 6;
        if (bus.req !== 1'b0) $display("FAIL reset_req got %0b want 0", bus.req); else pass_cnt++;
        if (bus.addr !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.addr); else pass_cnt++;
        if (vld !== 1'b0) $display("FAIL reset_valid got %0b want 0", vld); else pass_cnt++;
        if (instr !== 32'h13) $display("FAIL reset_instr got %h want 00000013", instr); else pass_cnt++;
        if (pc !== 32'h0) $display("FAIL reset_pc got %h want 0", pc); else pass_cnt++;
        if (ferr !== 1'b0) $display("FAIL reset_err got %0b want 0", ferr); else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.req !== 1'b1) $display("FAIL first_req got %0b want 1", bus.req); else pass_cnt++;
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (vld !== 1'b0) $display("FAIL stream_lat valid got %0b want 0", vld); else pass_cnt++;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            total_cnt++;
            if (vld !== 1'b1 || pc !== 32'(4*n) || instr !== mem(32'(4*n)))
                $display("FAIL stream_%0d got v=%0b pc=%h i=%h want v=1 pc=%h i=%h",
                         n, vld, pc, instr, 32'(4*n), mem(32'(4*n)));
            else pass_cnt++;
        end
    endtask

    task automatic test_holding();
        logic [31:0] exp_pc;
        do_reset();
        repeat (5) @(posedge clk);
        #1 hold = 1'b1;
        @(negedge clk);
        exp_pc = 32'(4 * obs.size());
        for (int n = 0; n < 6; n++) begin
            if (n > 0) @(negedge clk);
            total_cnt++;
            if (vld !== 1'b1 || pc !== exp_pc)
                $display("FAIL hold_pc_%0d got v=%0b pc=%h want v=1 pc=%h", n, vld, pc, exp_pc);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.req !== 1'b0) $display("FAIL hold_req got %0b want 0", bus.req); else pass_cnt++;
        @(posedge clk);
        #1 hold = 1'b0;
        repeat (12) @(negedge clk);
        total_cnt++;
        if (obs.size() < 14) $display("FAIL hold_count got %0d want >=14", obs.size()); else pass_cnt++;
        for (int i = 0; i < obs.size(); i++) begin
            total_cnt++;
            if (obs[i].pc !== 32'(4*i) || obs[i].instr !== mem(32'(4*i)))
                $display("FAIL hold_seq_%0d got pc=%h i=%h want pc=%h", i, obs[i].pc, obs[i].instr, 32'(4*i));
            else pass_cnt++;
        end
    endtask

    task automatic test_jump_inflight();
        fix_dly = 3;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        #1 begin jump = 1'b1; jaddr = 32'h100; end
        @(negedge clk);
        total_cnt++;
        if (bus.req !== 1'b0) $display("FAIL jump_req got %0b want 0", bus.req); else pass_cnt++;
        @(posedge clk);
        #1 jump = 1'b0;
        repeat (20) @(negedge clk);
        fix_dly = 0;
        total_cnt += 2;
        if (obs.size() < 2) begin
            $display("FAIL jump_count got %0d want >=2", obs.size());
        end else begin
            if (obs[0].pc !== 32'h100 || obs[0].instr !== mem(32'h100))
                $display("FAIL jump_first got pc=%h i=%h want pc=00000100 i=%h", obs[0].pc, obs[0].instr, mem(32'h100));
            else pass_cnt++;
            if (obs[1].pc !== 32'h104) $display("FAIL jump_second got pc=%h want 00000104", obs[1].pc);
            else pass_cnt++;
        end
    endtask

    task automatic test_jump_unaligned();
        do_reset();
        repeat (5) @(posedge clk);
        #1 begin jump = 1'b1; jaddr = 32'h103; end
        @(posedge clk);
        #1 jump = 1'b0;
        obs.delete();
        @(negedge clk);
        total_cnt++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h100)
            $display("FAIL jump_align got req=%0b addr=%h want req=1 addr=00000100", bus.req, bus.addr);
        else pass_cnt++;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (obs.size() < 2 || obs[0].pc !== 32'h100 || obs[1].pc !== 32'h104)
            $display("FAIL jump_align_stream got n=%0d pc0=%h want pc0=00000100 pc1=00000104",
                     obs.size(), (obs.size() > 0) ? obs[0].pc : 32'hx);
        else pass_cnt++;
    endtask

    task automatic test_error();
        err_en = 1;
        do_reset();
        repeat (12) @(negedge clk);
        err_en = 0;
        total_cnt += 3;
        if (obs.size() < 4) begin
            $display("FAIL err_count got %0d want >=4", obs.size());
        end else begin
            if (obs[1].err !== 1'b0) $display("FAIL err_before got %0b want 0", obs[1].err); else pass_cnt++;
            if (obs[2].pc !== 32'h8 || obs[2].instr !== 32'h13 || obs[2].err !== 1'b1)
                $display("FAIL err_entry got pc=%h i=%h e=%0b want pc=00000008 i=00000013 e=1",
                         obs[2].pc, obs[2].instr, obs[2].err);
            else pass_cnt++;
            if (obs[3].pc !== 32'hC || obs[3].instr !== mem(32'hC) || obs[3].err !== 1'b0)
                $display("FAIL err_after got pc=%h i=%h e=%0b want pc=0000000c e=0", obs[3].pc, obs[3].instr, obs[3].err);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        rand_gnt = 1; rand_dly = 1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1 hold = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #1 hold = 1'b0;
        rand_gnt = 0; rand_dly = 0;
        repeat (60) @(negedge clk);
        total_cnt++;
        if (obs.size() < 60) $display("FAIL rand_count got %0d want >=60", obs.size()); else pass_cnt++;
        for (int i = 0; i < obs.size(); i++) begin
            total_cnt++;
            if (obs[i].pc !== 32'(4*i) || obs[i].instr !== mem(32'(4*i)) || obs[i].err !== 1'b0)
                $display("FAIL rand_seq_%0d got pc=%h i=%h want pc=%h i=%h",
                         i, obs[i].pc, obs[i].instr, 32'(4*i), mem(32'(4*i)));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (vld !== 1'b0 || bus.req !== 1'b0 || bus.addr !== 32'h0 || pc !== 32'h0 ||
            instr !== 32'h13 || ferr !== 1'b0)
            $display("FAIL midreset got v=%0b req=%0b addr=%h pc=%h i=%h e=%0b want 0/0/0/0/13/0",
                     vld, bus.req, bus.addr, pc, instr, ferr);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs.delete();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (obs.size() < 2 || obs[0].pc !== 32'h0 || obs[1].pc !== 32'h4)
            $display("FAIL midreset_restart got n=%0d pc0=%h want pc0=0 pc1=4",
                     obs.size(), (obs.size() > 0) ? obs[0].pc : 32'hx);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_holding();
        test_jump_inflight();
        test_jump_unaligned();
        test_error();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
